// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared types and constants for the UART transmit arbiter.
//               The state enum grows WAIT_HDR / START_DATA only when the
//               UART_ARB_ID_HEADER_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

  // Header frames carry the requester index with the top bit set
  localparam logic [7:0] HDR_MARK = 8'h80;
  localparam int         MAX_REQ  = 8;

`ifdef UART_ARB_ID_HEADER_EN
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_HDR   = 2'd1,
    ST_START_DATA = 2'd2,
    ST_WAIT_DATA  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd3
  } state_e;
`endif

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin picker. Searches the request
//               vector from ptr_i upward with wrap-around and returns the
//               first requester as a one-hot grant plus its binary index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  // Rotate so ptr_i sits at bit 0, take the lowest set bit, then undo the rotation
  always_comb begin
    rot = N'({req_i, req_i} >> ptr_i);
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    idx_o   = sum[IW-1:0];
    gnt_o   = {{(N - 1){1'b0}}, 1'b1} << idx_o;
    valid_o = |req_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin scheduler sharing one uart_tx among NUM_REQ byte
//               producers. Latches the winning byte, issues a one-cycle
//               tx_start and blocks further grants until tx_done.
//               Optional feature macro: UART_ARB_ID_HEADER_EN - each grant
//               sends a header frame (8'h80 | grant_id) before the payload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_done_i,
  output logic                 busy_o,
  output logic [IDW-1:0]       grant_id_o
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
`ifdef UART_ARB_ID_HEADER_EN
  logic [7:0]           data_q, data_d;
`endif

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDW-1:0]       arb_idx;
  logic                 arb_valid;
  logic [7:0]           sel_byte;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Byte mux driven by the one-hot grant
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_byte = req_data_i[8*i +: 8];
    end
  end

  // Next-state logic; tx_done is only honoured once the start pulse has passed
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    req_ready_d = '0;
`ifdef UART_ARB_ID_HEADER_EN
    data_d      = data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          req_ready_d = arb_gnt;
          tx_start_d  = 1'b1;
          grant_d     = arb_idx;
          ptr_d       = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + IDW'(1);
`ifdef UART_ARB_ID_HEADER_EN
          data_d      = sel_byte;
          tx_data_d   = HDR_MARK | 8'(arb_idx);
          state_d     = ST_WAIT_HDR;
`else
          tx_data_d   = sel_byte;
          state_d     = ST_WAIT_DATA;
`endif
        end
      end
`ifdef UART_ARB_ID_HEADER_EN
      ST_WAIT_HDR: begin
        if (tx_done_i && !tx_start_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = data_q;
          state_d    = ST_START_DATA;
        end
      end
      ST_START_DATA: begin
        state_d = ST_WAIT_DATA;
      end
`endif
      ST_WAIT_DATA: begin
        if (tx_done_i && !tx_start_q) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset also discards any latched byte
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
`ifdef UART_ARB_ID_HEADER_EN
      data_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      req_ready_q <= req_ready_d;
`ifdef UART_ARB_ID_HEADER_EN
      data_q      <= data_d;
`endif
    end
  end

  assign req_ready_o = req_ready_q;
  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4).
//               Plays the role of uart_tx by pulsing tx_done by hand.
//               With UART_ARB_ID_HEADER_EN defined the header sequence runs
//               instead of the single-frame sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(4)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .tx_done_i   (tx_done),
    .busy_o      (busy),
    .grant_id_o  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // tx_done high for exactly one cycle; returns in the cycle after it
  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_id;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    tick();
    tick();
    chk("rst_busy",  busy,      0);
    chk("rst_start", tx_start,  0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data",  tx_data,   0);
    chk("rst_gid",   grant_id,  0);
    reset = 1'b0;
    tick();

`ifdef UART_ARB_ID_HEADER_EN
    // Requester 3 sends 8'h55: header 8'h83 then payload, one req_ready
    req_data  = 32'h5500_0000;
    req_valid = 4'b1000;
    tick();
    chk("hdr_start",  tx_start,  1);
    chk("hdr_data",   tx_data,   8'h83);
    chk("hdr_ready",  req_ready, 4'b1000);
    chk("hdr_gid",    grant_id,  3);
    chk("hdr_busy",   busy,      1);
    req_valid = '0;
    tick();
    chk("hdr_start_pulse", tx_start,  0);
    chk("hdr_ready_pulse", req_ready, 0);
    tick();
    pulse_done();
    chk("pay_start", tx_start,  1);
    chk("pay_data",  tx_data,   8'h55);
    chk("pay_ready", req_ready, 0);
    chk("pay_busy",  busy,      1);
    tick();
    chk("pay_start_pulse", tx_start, 0);
    chk("pay_data_hold",   tx_data,  8'h55);
    tick();
    pulse_done();
    chk("pay_busy_fall", busy,     0);
    chk("pay_no_start",  tx_start, 0);
`else
    // Single request from requester 2
    req_data  = 32'h0041_0000;
    req_valid = 4'b0100;
    tick();
    chk("single_ready", req_ready, 4'b0100);
    chk("single_start", tx_start,  1);
    chk("single_data",  tx_data,   8'h41);
    chk("single_gid",   grant_id,  2);
    chk("single_busy",  busy,      1);
    req_valid = '0;
    tick();
    chk("single_start_pulse", tx_start,  0);
    chk("single_ready_pulse", req_ready, 0);
    tick();
    chk("single_busy_hold", busy, 1);
    pulse_done();
    chk("single_busy_fall", busy,    0);
    chk("single_data_keep", tx_data, 8'h41);

    // Spurious tx_done while idle
    pulse_done();
    chk("spur_busy",  busy,     0);
    chk("spur_start", tx_start, 0);
    tick();
    chk("spur_start2", tx_start, 0);

    // Back-to-back: requester 1 alone, keeps req_valid high
    req_data  = 32'h0000_2200;
    req_valid = 4'b0010;
    tick();
    chk("b2b_start1", tx_start,  1);
    chk("b2b_gid1",   grant_id,  1);
    chk("b2b_ready1", req_ready, 4'b0010);
    tick();
    tick();
    chk("b2b_busy_mid", busy, 1);
    pulse_done();
    chk("b2b_gap_start", tx_start, 0);
    chk("b2b_gap_busy",  busy,     0);
    tick();
    chk("b2b_start2", tx_start,  1);
    chk("b2b_ready2", req_ready, 4'b0010);
    chk("b2b_data2",  tx_data,   8'h22);
    req_valid = '0;
    // tx_done in the start cycle must be ignored
    pulse_done();
    chk("b2b_done_in_start", busy, 1);

    // Reset mid-frame
    tick();
    reset = 1'b1;
    #1;
    chk("mrst_busy",  busy,      0);
    chk("mrst_start", tx_start,  0);
    chk("mrst_ready", req_ready, 0);
    chk("mrst_data",  tx_data,   0);
    chk("mrst_gid",   grant_id,  0);
    req_data  = 32'h0000_00A5;
    req_valid = 4'b0001;
    tick();
    chk("mrst_hold_idle", tx_start, 0);
    reset = 1'b0;
    tick();
    chk("mrst_start0", tx_start,  1);
    chk("mrst_ready0", req_ready, 4'b0001);
    chk("mrst_gid0",   grant_id,  0);
    chk("mrst_data0",  tx_data,   8'hA5);
    req_valid = '0;
    tick();
    pulse_done();
    chk("mrst_busy_fall", busy, 0);

    // Fairness from ptr=0 with all four requesters held valid
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_data  = 32'h1312_1110;
    req_valid = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_id = k % 4;
      chk("fair_start", tx_start,  1);
      chk("fair_gid",   grant_id,  exp_id);
      chk("fair_data",  tx_data,   8'h10 + exp_id);
      chk("fair_ready", req_ready, 1 << exp_id);
      tick();
      tick();
      pulse_done();
      chk("fair_busy_fall", busy, 0);
      tick();
    end
    req_valid = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
